kronos_wb_arb: RTL and testbench



---
 rtl/kronos_wb_arb_if.sv | 29 ++
 rtl/kronos_wb_arb.sv | 123 ++++++++++++
 tb/tb_kronos_wb_arb.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kronos_wb_arb_if.sv
// Write-back arbiter bus: producer handshakes in, register-file write out.
//   req_vld/req_rd/req_data : per-requester result offer (producer -> arbiter)
//   req_rdy                 : per-requester slot can accept (arbiter -> producer)
//   hold                    : suspend all grants (debug owns the write port)
//   regwr_en/sel/data       : registered register-file write (arbiter -> ID)
//   busy                    : any slot full or a write in flight
interface kronos_wb_arb_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0][4:0]  req_rd;
  logic [NREQ-1:0][31:0] req_data;
  logic                  hold;
  logic                  regwr_en;
  logic [4:0]            regwr_sel;
  logic [31:0]           regwr_data;
  logic                  busy;

  modport master (
    output req_vld, req_rd, req_data, hold,
    input  req_rdy, regwr_en, regwr_sel, regwr_data, busy
  );

  modport slave (
    input  req_vld, req_rd, req_data, hold,
    output req_rdy, regwr_en, regwr_sel, regwr_data, busy
  );
endinterface

// File: rtl/kronos_wb_arb.sv
// Write-back arbiter for the single register-file write port.
// One result slot per requester; round-robin grant of one slot per cycle,
// with writes to the same rd retiring in requester-index order.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : kronos_wb_arb_if.slave (requests in, registered write out)
module kronos_wb_arb #(
  parameter int unsigned NREQ = 3
) (
  input  logic           clk,
  input  logic           rst,
  kronos_wb_arb_if.slave bus
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0]       full_q, full_d;
  logic [NREQ-1:0][4:0]  rd_q, rd_d;
  logic [NREQ-1:0][31:0] data_q, data_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  regwr_en_q;
  logic [4:0]            regwr_sel_q;
  logic [31:0]           regwr_data_q;

  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rdy;
  logic                  gnt_vld;
  logic [PW-1:0]         win;

  // A slot is blocked while any lower-index (older) slot targets the same rd.
  always_comb begin
    elig = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      elig[j] = full_q[j] & ~bus.hold;
      for (int unsigned i = 0; i < j; i++) begin
        if (full_q[i] && (rd_q[i] == rd_q[j])) elig[j] = 1'b0;
      end
    end
  end

  // First eligible slot at or after ptr, wrapping modulo NREQ.
  always_comb begin : p_pick
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    win     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && elig[idx[PW-1:0]]) begin
        gnt_vld = 1'b1;
        win     = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i] = gnt_vld && (win == PW'(i));
    end
  end

  // Ready depends only on registered state and hold, never on req_vld.
  assign rdy         = ~full_q | gnt;
  assign bus.req_rdy = rdy;

  // Slot update: grant drains, an accepted transfer refills; rd==0 is dropped.
  always_comb begin
    full_d = full_q;
    rd_d   = rd_q;
    data_d = data_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) full_d[i] = 1'b0;
      if (bus.req_vld[i] && rdy[i]) begin
        if (bus.req_rd[i] != 5'd0) begin
          full_d[i] = 1'b1;
          rd_d[i]   = bus.req_rd[i];
          data_d[i] = bus.req_data[i];
        end else begin
          full_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      if (win == PW'(NREQ - 1)) ptr_d = '0;
      else                      ptr_d = win + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= '0;
      rd_q         <= '0;
      data_q       <= '0;
      ptr_q        <= '0;
      regwr_en_q   <= 1'b0;
      regwr_sel_q  <= '0;
      regwr_data_q <= '0;
    end else begin
      full_q     <= full_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      ptr_q      <= ptr_d;
      regwr_en_q <= gnt_vld;
      if (gnt_vld) begin
        regwr_sel_q  <= rd_q[win];
        regwr_data_q <= data_q[win];
      end
    end
  end

  assign bus.regwr_en   = regwr_en_q;
  assign bus.regwr_sel  = regwr_sel_q;
  assign bus.regwr_data = regwr_data_q;
  assign bus.busy       = (|full_q) | regwr_en_q;

endmodule

// File: tb/tb_kronos_wb_arb.sv
// Bench for kronos_wb_arb: directed scenarios plus random traffic, every
// cycle compared against a slot/queue model of the arbitration rules.
module tb_kronos_wb_arb;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kronos_wb_arb_if #(.NREQ(N)) bus ();

  kronos_wb_arb #(.NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_full [N];
  logic [4:0]  m_rd   [N];
  logic [31:0] m_data [N];
  int          m_ptr;
  logic        m_en;
  logic [4:0]  m_sel;
  logic [31:0] m_wdata;
  logic [N-1:0] m_acc;

  // Staged stimulus for the next cycle
  logic [N-1:0]       s_vld;
  logic [N-1:0][4:0]  s_rd;
  logic [N-1:0][31:0] s_data;
  logic               s_hold;

  // Writes observed on the register-file port
  logic [4:0]  wsel [$];
  logic [31:0] wdat [$];

  int  c0, c1;
  bit  seen [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit older_same(input int j);
    for (int i = 0; i < j; i++)
      if (m_full[i] && m_rd[i] == m_rd[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Winner index, or -1 when nothing can be granted.
  function automatic int pick(input logic h);
    if (h) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_full[j] && !older_same(j)) return j;
    end
    return -1;
  endfunction

  function automatic bit any_full();
    for (int i = 0; i < N; i++) if (m_full[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0; m_en = 1'b0; m_sel = '0; m_wdata = '0; m_acc = '0;
  endtask

  task automatic set_in(input logic [N-1:0] v,
                        input logic [4:0] r0, input logic [31:0] d0,
                        input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2,
                        input logic h);
    s_vld = v;
    s_rd[0] = r0; s_data[0] = d0;
    s_rd[1] = r1; s_data[1] = d1;
    s_rd[2] = r2; s_data[2] = d2;
    s_hold = h;
  endtask

  task automatic idle();
    set_in('0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
  endtask

  // One clock: drive staged inputs, check ready, advance model, check outputs.
  task automatic step();
    int w;
    logic [N-1:0] erdy;
    @(negedge clk);
    bus.req_vld = s_vld; bus.req_rd = s_rd; bus.req_data = s_data; bus.hold = s_hold;
    #1;
    w = pick(s_hold);
    for (int i = 0; i < N; i++) erdy[i] = !m_full[i] || (i == w);
    chk("req_rdy", 64'(bus.req_rdy), 64'(erdy));
    m_acc = s_vld & erdy;
    if (w >= 0) begin
      m_en = 1'b1; m_sel = m_rd[w]; m_wdata = m_data[w];
      m_full[w] = 1'b0; m_ptr = (w + 1) % N;
    end else begin
      m_en = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        if (s_rd[i] != 5'd0) begin
          m_full[i] = 1'b1; m_rd[i] = s_rd[i]; m_data[i] = s_data[i];
        end else begin
          m_full[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("regwr_en",   64'(bus.regwr_en),   64'(m_en));
    chk("regwr_sel",  64'(bus.regwr_sel),  64'(m_sel));
    chk("regwr_data", 64'(bus.regwr_data), 64'(m_wdata));
    chk("busy",       64'(bus.busy),       64'(any_full() | m_en));
    if (bus.regwr_en) begin
      wsel.push_back(bus.regwr_sel);
      wdat.push_back(bus.regwr_data);
    end
  endtask

  // Asynchronous reset assertion mid-cycle with offers pending on all inputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_vld = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_rd[i] = 5'(i + 1); bus.req_data[i] = 32'hC0DE_0000 + 32'(i);
    end
    bus.hold = 1'b0;
    #1;
    chk("rst_en",   64'(bus.regwr_en),   64'd0);
    chk("rst_sel",  64'(bus.regwr_sel),  64'd0);
    chk("rst_data", 64'(bus.regwr_data), 64'd0);
    chk("rst_busy", 64'(bus.busy),       64'd0);
    chk("rst_rdy",  64'(bus.req_rdy),    64'(3'b111));
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_busy_edge", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_vld = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_vld = '0; bus.req_rd = '0; bus.req_data = '0; bus.hold = 1'b0;
    idle();
    m_reset();
    #1;
    chk("init_en",   64'(bus.regwr_en),   64'd0);
    chk("init_busy", 64'(bus.busy),       64'd0);
    chk("init_rdy",  64'(bus.req_rdy),    64'(3'b111));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Latency: single transfer appears on the write port two edges later.
    set_in(3'b001, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    step();
    chk("lat_t1_en", 64'(bus.regwr_en), 64'd0);
    idle(); step();
    chk("lat_t2_en",   64'(bus.regwr_en),   64'd1);
    chk("lat_t2_sel",  64'(bus.regwr_sel),  64'd5);
    chk("lat_t2_data", 64'(bus.regwr_data), 64'hDEAD_BEEF);
    step();
    chk("lat_t3_en", 64'(bus.regwr_en), 64'd0);

    // Round robin from ptr=0 with immediate refills.
    do_reset();
    wsel.delete(); wdat.delete();
    set_in(3'b111, 5'd1, 32'h101, 5'd2, 32'h102, 5'd3, 32'h103, 1'b0);
    repeat (4) step();
    idle();
    repeat (4) step();
    chk("rr_count", 64'(wsel.size()), 64'd6);
    for (int k = 0; k < 6 && k < wsel.size(); k++)
      chk("rr_order", 64'(wsel[k]), 64'((k % 3) + 1));
    // ptr wrapped to 0: slot0 must beat slot2.
    wsel.delete(); wdat.delete();
    set_in(3'b101, 5'd10, 32'h10, 5'd0, 32'd0, 5'd20, 32'h20, 1'b0);
    step(); idle(); repeat (3) step();
    chk("wrap_count", 64'(wsel.size()), 64'd2);
    if (wsel.size() == 2) begin
      chk("wrap_first",  64'(wsel[0]), 64'd10);
      chk("wrap_second", 64'(wsel[1]), 64'd20);
    end

    // Same-rd ordering with ptr=1 (one write from slot0 moves ptr there).
    set_in(3'b001, 5'd4, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    step(); idle(); repeat (2) step();
    wsel.delete(); wdat.delete();
    set_in(3'b011, 5'd7, 32'h11, 5'd7, 32'h22, 5'd0, 32'd0, 1'b0);
    step(); idle(); repeat (4) step();
    chk("samerd_count", 64'(wdat.size()), 64'd2);
    if (wdat.size() == 2) begin
      chk("samerd_first",  64'(wdat[0]), 64'h11);
      chk("samerd_second", 64'(wdat[1]), 64'h22);
    end

    // x0 destination is accepted and dropped.
    wsel.delete(); wdat.delete();
    set_in(3'b010, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
    step();
    chk("x0_en",   64'(bus.regwr_en), 64'd0);
    chk("x0_busy", 64'(bus.busy),     64'd0);
    idle(); step();
    chk("x0_rdy1",  64'(bus.req_rdy[1]), 64'd1);
    chk("x0_none",  64'(wsel.size()),    64'd0);

    // Hold freezes grants; slot2 still fills and stays pending.
    set_in(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'h99, 1'b1);
    step();
    set_in('0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_en",   64'(bus.regwr_en),   64'd0);
      chk("hold_rdy2", 64'(bus.req_rdy[2]), 64'd0);
    end
    idle(); step();
    chk("unhold_en",  64'(bus.regwr_en),  64'd1);
    chk("unhold_sel", 64'(bus.regwr_sel), 64'd9);

    // Two requesters streaming with backpressure.
    idle(); step();
    wsel.delete(); wdat.delete();
    c0 = 0; c1 = 0;
    for (int s = 0; s < 40 && (c0 < 10 || c1 < 10); s++) begin
      set_in({1'b0, c1 < 10, c0 < 10},
             5'(1 + c0),  32'hA000_0000 + 32'(c0),
             5'(11 + c1), 32'hB000_0000 + 32'(c1),
             5'd0, 32'd0, 1'b0);
      step();
      if (m_acc[0]) c0++;
      if (m_acc[1]) c1++;
    end
    idle(); repeat (4) step();
    chk("stream_count", 64'(wsel.size()), 64'd20);
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int k = 0; k < wsel.size(); k++) begin
      chk("stream_dup", 64'(seen[wsel[k]]), 64'd0);
      seen[wsel[k]] = 1'b1;
      if (k > 0)
        chk("stream_alt", 64'((wsel[k] > 5'd10) != (wsel[k-1] > 5'd10)), 64'd1);
    end

    // Reset with writes in flight and slots full.
    set_in(3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3, 1'b1);
    step();
    idle(); step();
    chk("pre_rst_en", 64'(bus.regwr_en), 64'd1);
    do_reset();

    // Random traffic, with one reset in the middle.
    for (int s = 0; s < 400; s++) begin
      s_vld = 3'($urandom);
      for (int i = 0; i < N; i++) begin
        s_rd[i]   = 5'($urandom_range(0, 7));
        s_data[i] = $urandom;
      end
      s_hold = ($urandom_range(0, 7) == 0);
      step();
      if (s == 200) do_reset();
    end
    idle(); repeat (6) step();
    chk("final_busy", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
